// File: rtl/alu_sequencer.sv
// Drives every opcode through an external ALU with fixed operands and stores each result in a buffer.
// Optional XOR checksum of the sweep's results: define ALU_SEQ_CHECKSUM_EN (otherwise checksum is tied to 0).
module alu_sequencer #(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_instr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [OP_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] checksum
);

  localparam int DEPTH = 2**OP_W;
  localparam logic [OP_W-1:0] K_LAST = OP_W'(DEPTH - 1);
  localparam logic [OP_W-1:0] K_ONE  = OP_W'(1);
  // WAIT spans ALU_LAT-1 cycles; the counter's last value is ALU_LAT-2.
  localparam logic [2:0] WAIT_LAST = (ALU_LAT > 1) ? 3'(ALU_LAT - 2) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t                       state;
  logic [OP_W-1:0]              k;
  logic [2:0]                   cnt;
  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_instr <= '0;
      k         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            alu_a     <= a_in;
            alu_b     <= b_in;
            k         <= '0;
            alu_instr <= '0;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= (ALU_LAT > 1) ? S_WAIT : S_CAPTURE;
        end
        S_WAIT: begin
          cnt <= cnt + 3'd1;
          if (cnt == WAIT_LAST) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (k == K_LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k         <= k + K_ONE;
            alu_instr <= k + K_ONE;
            state     <= S_ISSUE;
          end
        end
        S_DONE: begin
          // start is deliberately not sampled here; the next sweep needs one IDLE cycle.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reads see contents as of the previous edge, even when the same entry is being captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '0;
      rd_data <= '0;
    end else begin
      if (state == S_CAPTURE) mem[k] <= alu_result;
      rd_data <= mem[rd_addr];
    end
  end

`ifdef ALU_SEQ_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (state == S_CAPTURE)       checksum <= checksum ^ alu_result;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: two sequencers (ALU_LAT=1 and ALU_LAT=3) each driven by a stub ALU.
module tb_alu_sequencer;
  localparam int DW = 4;
  localparam int OW = 4;
`ifdef ALU_SEQ_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start1 = 1'b0, start3 = 1'b0;
  logic [DW-1:0] a_in = '0, b_in = '0;
  logic [OW-1:0] rd_addr = '0;
  logic          busy1, done1, busy3, done3;
  logic [DW-1:0] alu_a1, alu_b1, rd_data1, csum1, res1;
  logic [DW-1:0] alu_a3, alu_b3, rd_data3, csum3, res3;
  logic [OW-1:0] alu_instr1, alu_instr3;
  logic [2:0][DW-1:0] p3;
  int mode = 0;
  int cyc = 0;

  alu_sequencer #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_instr(alu_instr1),
    .alu_result(res1), .rd_addr(rd_addr), .rd_data(rd_data1), .checksum(csum1));

  alu_sequencer #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a_in), .b_in(b_in),
    .busy(busy3), .done(done3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_instr(alu_instr3),
    .alu_result(res3), .rd_addr(rd_addr), .rd_data(rd_data3), .checksum(csum3));

  // Stub ALU: mode 0 instr^A, mode 1 5 for instr 0 else 0, mode 2 instr+1.
  function automatic logic [DW-1:0] stub_f(int m, logic [OW-1:0] i, logic [DW-1:0] a);
    case (m)
      0:       return i ^ a;
      1:       return (i == '0) ? 4'd5 : 4'd0;
      default: return i + 4'd1;
    endcase
  endfunction

  always @(posedge clk) res1 <= stub_f(mode, alu_instr1, alu_a1);
  always @(posedge clk) begin
    p3[0] <= stub_f(mode, alu_instr3, alu_a3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign res3 = p3[2];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int sel; int cyc; logic [DW-1:0] a; logic [DW-1:0] cs;} done_t;
  typedef struct {int sel; int addr; logic [DW-1:0] exp;} rd_t;
  done_t done_q[$];
  rd_t   rd_q[$];
  int n_cmp = 0, n_bad = 0;
  logic rd_issue = 1'b0, rd_vld = 1'b0;
  always @(posedge clk) rd_vld <= rd_issue;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not match scoreboard", nm);
  endtask

  function automatic logic [DW-1:0] csx(logic [DW-1:0] v);
    return CS_EN ? v : '0;
  endfunction

  // Monitor: pops expectations whenever a DUT presents read data or a done pulse.
  initial begin
    rd_t r;
    done_t d;
    forever begin
      @(negedge clk);
      if (rd_vld) begin
        if (rd_q.size() == 0) fail("rd_unexpected");
        else begin
          r = rd_q.pop_front();
          chk($sformatf("rd%0d[%0h]", r.sel, r.addr), (r.sel != 0) ? rd_data3 : rd_data1, r.exp);
        end
      end
      if (done1 || done3) begin
        if (done_q.size() == 0) fail("done_unexpected");
        else begin
          d = done_q.pop_front();
          chk("done_dut", done3 ? 1 : 0, d.sel);
          chk("done_cyc", cyc, d.cyc);
          chk("done_alu_a", (d.sel != 0) ? alu_a3 : alu_a1, d.a);
          chk("done_csum", (d.sel != 0) ? csum3 : csum1, d.cs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep1(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] cs);
    a_in = a;
    b_in = b;
    start1 = 1'b1;
    done_q.push_back('{0, cyc + 1 + 32, a, csx(cs)});
    tick();
    start1 = 1'b0;
  endtask

  task automatic rd(int sel, logic [OW-1:0] addr, logic [DW-1:0] exp);
    rd_addr = addr;
    rd_issue = 1'b1;
    rd_q.push_back('{sel, int'(addr), exp});
    tick();
    rd_issue = 1'b0;
  endtask

  initial begin
    int ea;
    repeat (2) tick();
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_alu_a", alu_a1, 0);
    chk("rst_alu_b", alu_b1, 0);
    chk("rst_instr", alu_instr1, 0);
    chk("rst_rd_data", rd_data1, 0);
    chk("rst_csum", csum1, 0);
    chk("rst_busy3", busy3, 0);
    rst_n = 1'b1;
    tick();

    // Basic sweep: result = instr ^ 7.
    mode = 0;
    sweep1(4'h7, 4'hA, 4'h0);
    chk("busy_after_start", busy1, 1);
    repeat (3) tick();
    chk("alu_b_held", alu_b1, 4'hA);
    repeat (30) tick();
    rd(0, 4'h3, 4'h4);
    rd(0, 4'hF, 4'h8);
    rd(0, 4'h0, 4'h7);
    repeat (2) tick();

    // start re-pulsed mid-sweep with new operands is ignored.
    sweep1(4'h7, 4'hA, 4'h0);
    repeat (9) tick();
    a_in = 4'h3;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("alu_a_held", alu_a1, 4'h7);
    repeat (25) tick();

    // Checksum patterns.
    mode = 1;
    sweep1(4'h0, 4'h0, 4'h5);
    repeat (34) tick();
    rd(0, 4'h0, 4'h5);
    rd(0, 4'h1, 4'h0);
    mode = 2;
    sweep1(4'h2, 4'h0, 4'h0);
    repeat (34) tick();
    rd(0, 4'h0, 4'h1);
    rd(0, 4'hF, 4'h0);
    repeat (2) tick();

    // start held high: back-to-back sweeps with one IDLE cycle between.
    mode = 0;
    a_in = 4'h1;
    b_in = 4'h0;
    start1 = 1'b1;
    ea = cyc + 1;
    done_q.push_back('{0, ea + 32, 4'h1, csx(4'h0)});
    done_q.push_back('{0, ea + 66, 4'h1, csx(4'h0)});
    tick();
    repeat (33) tick();
    chk("b2b_idle_busy", busy1, 0);
    tick();
    chk("b2b_restart_busy", busy1, 1);
    repeat (10) tick();
    start1 = 1'b0;
    repeat (34) tick();
    chk("b2b_end_busy", busy1, 0);

    // ALU_LAT=3: each opcode held 4 cycles, done after 64.
    a_in = 4'h5;
    start3 = 1'b1;
    done_q.push_back('{1, cyc + 1 + 64, 4'h5, csx(4'h0)});
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("lat3_instr@%0d", i), alu_instr3, i / 4);
      tick();
    end
    repeat (2) tick();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      kk = 4'(k);
      rd(1, kk, kk ^ 4'h5);
    end
    repeat (2) tick();

    // Reset mid-sweep: abort, no done, buffer cleared.
    a_in = 4'h7;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_alu_a", alu_a1, 0);
    chk("midrst_instr", alu_instr1, 0);
    chk("midrst_rd_data", rd_data1, 0);
    chk("midrst_csum", csum1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy1, 0);
    rd(0, 4'h2, 4'h0);
    repeat (40) tick();

    if (done_q.size() != 0) fail("done_missing");
    if (rd_q.size() != 0) fail("rd_missing");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
